// File: rtl/wb_host_master.sv
// Wishbone classic-cycle initiator for test and bring-up logic.
// Takes one read/write command at a time, runs a single CYC/STB cycle
// until ACK (or a timeout abort), and returns the result on a response port.
module wb_host_master #(
  parameter int TIMEOUT = 64,
  parameter int ADDR_W  = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  // command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [3:0]        cmd_sel,
  input  logic [ADDR_W-1:0] cmd_adr,
  input  logic [31:0]       cmd_dat,
  // wishbone initiator
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [3:0]        wbm_sel_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [31:0]       wbm_dat_o,
  input  logic              wbm_ack_i,
  input  logic [31:0]       wbm_dat_i,
  // response port
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_dat,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Last counter value before the cycle is aborted. TIMEOUT is limited to
  // 2..255, so an 8-bit counter always suffices and never wraps.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            r_state;
  logic              r_cyc;
  logic              r_stb;
  logic              r_we;
  logic [3:0]        r_sel;
  logic [ADDR_W-1:0] r_adr;
  logic [31:0]       r_dat_o;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_dat;
  logic              r_rsp_err;
  logic [7:0]        r_cnt;

  logic w_cmd_fire;
  logic w_rsp_fire;
  logic w_timeout;

  assign w_cmd_fire = cmd_valid && (r_state == S_IDLE);
  assign w_rsp_fire = r_rsp_valid && rsp_ready;
  assign w_timeout  = (r_cnt == TO_LAST);

  // Single registered FSM: command capture, bus cycle with timeout, response hold.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= 4'd0;
      r_adr       <= '0;
      r_dat_o     <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= 32'd0;
      r_rsp_err   <= 1'b0;
      r_cnt       <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            r_we    <= cmd_we;
            r_sel   <= cmd_sel;
            r_adr   <= cmd_adr;
            r_dat_o <= cmd_dat;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_cnt   <= 8'd0;
            r_state <= S_BUS;
          end
        end

        S_BUS: begin
          // ACK has priority over a timeout landing in the same cycle.
          if (wbm_ack_i) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_dat   <= r_we ? 32'd0 : wbm_dat_i;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (w_timeout) begin
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_dat   <= 32'd0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end

        S_RESP: begin
          // ACK is not looked at here, so late or stray ACKs are harmless.
          if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cyc   <= 1'b0;
          r_stb   <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);

  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_stb;
  assign wbm_we_o  = r_we;
  assign wbm_sel_o = r_sel;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat_o;

  assign rsp_valid = r_rsp_valid;
  assign rsp_dat   = r_rsp_dat;
  assign rsp_err   = r_rsp_err;

endmodule

// File: doc/wb_host_master.md
Name: wb_host_master

Overview:
- Wishbone initiator for user-project test and bring-up logic.
- Accepts single read/write commands on a valid/ready command port and runs one classic Wishbone cycle (CYC/STB held until ACK) against a delayed-ACK responder such as the user BRAM wrapper.
- Returns read data, or a timeout error, on a valid/ready response port.
- One transaction in flight at a time; no pipelining, no bursts.

Parameters:
- TIMEOUT, 64: bus cycles to wait for ACK before aborting. Legal range 2..255.
- ADDR_W, 32: width of the address bus.

Ports:
- wb_clk_i  input  1  clock; all logic is on the rising edge.
- wb_rst_i  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_we  input  1  1 = write, 0 = read.
- cmd_sel  input  4  byte enables.
- cmd_adr  input  ADDR_W  byte address.
- cmd_dat  input  32  write data.
- wbm_cyc_o  output  1  Wishbone CYC.
- wbm_stb_o  output  1  Wishbone STB.
- wbm_we_o  output  1  Wishbone WE.
- wbm_sel_o  output  4  Wishbone SEL.
- wbm_adr_o  output  ADDR_W  Wishbone address.
- wbm_dat_o  output  32  Wishbone write data.
- wbm_ack_i  input  1  Wishbone ACK from the responder.
- wbm_dat_i  input  32  Wishbone read data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_dat  output  32  read data; 0 for writes and on error.
- rsp_err  output  1  1 = timeout abort.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Registered FSM with three states: IDLE, BUS, RESP. All outputs are registered or decoded directly from the state.
- Reset values (asynchronous, applied immediately on wb_rst_i):
  - state = IDLE.
  - cyc, stb, we = 0; sel = 0; adr = 0; dat_o = 0.
  - rsp_valid = 0; rsp_dat = 0; rsp_err = 0.
  - timeout counter = 0.
  - Reset during BUS drops CYC/STB immediately. The transaction is lost and no response is produced.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready: latch we/sel/adr/dat into the bus output registers, set cyc = stb = 1, clear the counter, go to BUS.
  - STB is therefore high in the cycle after the command handshake.
- BUS:
  - cmd_ready = 0.
  - wbm_*_o are held stable every cycle until the cycle ends.
  - Each cycle without ACK increments the counter.
  - ACK sampled high:
    - Next cycle cyc = stb = 0.
    - rsp_dat = wbm_dat_i if it was a read, else 0.
    - rsp_err = 0, rsp_valid = 1, go to RESP.
  - ACK and timeout in the same cycle: ACK wins.
  - Counter reaches TIMEOUT-1 with no ACK:
    - Next cycle cyc = stb = 0.
    - rsp_err = 1, rsp_dat = 0, rsp_valid = 1, go to RESP.
  - STB never drops without ACK except on timeout or reset.
- RESP:
  - rsp_valid is held with stable data until rsp_ready is high.
  - On rsp_valid && rsp_ready: rsp_valid = 0 next cycle, go to IDLE.
  - cmd_ready = 0, so a back-to-back command is accepted at the earliest one cycle after the response handshake.
- ACK is ignored outside BUS. A stray ACK in IDLE or RESP changes nothing.
- A late ACK that arrives after a timeout abort is ignored.
- Latency: command handshake at cycle 0 → STB high in cycles 1..N → ACK sampled in cycle N → rsp_valid in cycle N+1.
- Against the delayed-ACK BRAM responder with DELAYS=10, ACK arrives in the 10th STB cycle, so rsp_valid is high in cycle 11.
- No counter wrap: the counter saturates because the state always leaves BUS at TIMEOUT-1.

Test Plan:
- Write then read against the BRAM responder (DELAYS=10):
  - Write adr 0x10, dat 0xA5A5_1234, sel 0xF → STB high for exactly 10 cycles, rsp_valid at cycle 11, rsp_err = 0, rsp_dat = 0.
  - Read adr 0x10 → rsp_dat = 0xA5A5_1234.
- Byte enables:
  - Write 0xFFFF_FFFF with sel 0xF, then 0x0000_0000 with sel 0x5.
  - Read back → 0xFF00_FF00; wbm_sel_o = 0x5 throughout the second cycle.
- Timeout:
  - Run with TIMEOUT = 8 and the ACK tied low → STB high exactly 8 cycles, then rsp_err = 1, rsp_dat = 0.
  - Drive a late ACK afterwards → no state change.
- Response backpressure:
  - Hold rsp_ready = 0 for 5 cycles → rsp_valid and rsp_dat stable for all 5 cycles, cmd_ready = 0.
  - Raise rsp_ready → back in IDLE one cycle later.
- Reset mid-transaction:
  - Assert wb_rst_i in the 4th STB cycle → cyc/stb = 0 in the same cycle (asynchronous), no rsp_valid.
  - After release, a new read completes normally.
- Stray ACK and command stalls:
  - Pulse ACK in IDLE → nothing happens.
  - Hold cmd_valid during BUS → the second command is accepted only after the response handshake; its wbm_adr_o is correct.
